mmio_req_queue: RTL and testbench

- Buffers D-cache memory-mapped IO requests (address, rw, write data) in a small FIFO.
- Issues them one at a time to the SPART cache-side interface over a valid/ready handshake.
- Returns read data to the cache as a single-cycle response pulse.
- Sits between the D-cache memory port and the SPART interface, so cache stalls are decoupled from SPART latency.

---
 rtl/mmio_req_queue_if.sv | 40 ++++
 rtl/mmio_req_queue.sv | 198 +++++++++++++++++++
 tb/tb_mmio_req_queue.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_req_queue_if.sv
// mmio_req_queue_if: bundles the D-cache request/response signals and the
// SPART command channel that pass through mmio_req_queue.
//   cache side : cpu_valid/cpu_ready/cpu_rw/cpu_addr/cpu_wr_data (request),
//                cpu_rd_valid/cpu_rd_data/cpu_err (response pulse)
//   SPART side : io_valid_data/io_ready_data/io_rw_data/mem_addr/io_wr_data,
//                io_rd_data (read return)
// modport slave  : the queue itself
// modport master : the surroundings (cache + SPART), e.g. a testbench
interface mmio_req_queue_if #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 32
);
    logic              cpu_valid;
    logic              cpu_ready;
    logic              cpu_rw;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              cpu_rd_valid;
    logic [DATA_W-1:0] cpu_rd_data;
    logic              cpu_err;

    logic              io_rw_data;
    logic              io_valid_data;
    logic              io_ready_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] io_wr_data;
    logic [DATA_W-1:0] io_rd_data;

    modport slave (
        input  cpu_valid, cpu_rw, cpu_addr, cpu_wr_data, io_ready_data, io_rd_data,
        output cpu_ready, cpu_rd_valid, cpu_rd_data, cpu_err,
               io_rw_data, io_valid_data, mem_addr, io_wr_data
    );

    modport master (
        output cpu_valid, cpu_rw, cpu_addr, cpu_wr_data, io_ready_data, io_rd_data,
        input  cpu_ready, cpu_rd_valid, cpu_rd_data, cpu_err,
               io_rw_data, io_valid_data, mem_addr, io_wr_data
    );
endinterface

// File: rtl/mmio_req_queue.sv
// mmio_req_queue: small FIFO of D-cache MMIO requests issued one at a time
// to the SPART cache-side port; read data returns as a one-cycle pulse.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - mmio_req_queue_if.slave (cache request/response + SPART command)
// Parameters: DEPTH (power of 2, >= 2), ADDR_W, DATA_W, TIMEOUT.
// Optional feature macro MMIO_TIMEOUT_EN: abort a command that SPART has not
// completed within TIMEOUT cycles (cpu_err pulse, reads return 32'hDEADBEEF).
// Without the macro ISSUE waits indefinitely and cpu_err is tied 0.
module mmio_req_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADDR_W  = 28,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    mmio_req_queue_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    // Elaboration-time parameter sanity check
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_param
        $error("mmio_req_queue: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 2");
    end

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wr_data;
    } req_t;

    req_t              fifo_mem [DEPTH];
    req_t              req_in;
    req_t              head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              push;
    logic              pop;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic              cpu_ready_q;
    logic              ready_nxt;
    logic              io_valid_q;
    logic              io_valid_nxt;
    req_t              io_req_q;
    req_t              io_req_nxt;
    logic              rd_valid_q;
    logic              rd_valid_nxt;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_nxt;

`ifdef MMIO_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT);
    logic              err_q;
    logic              err_nxt;
    logic [TMO_W-1:0]  tmo_q;
    logic [TMO_W-1:0]  tmo_nxt;
`endif

    assign req_in = '{rw: bus.cpu_rw, addr: bus.cpu_addr, wr_data: bus.cpu_wr_data};
    assign head   = fifo_mem[rd_ptr];
    assign push   = bus.cpu_valid & cpu_ready_q;

    // Occupancy update; a push and a pop in the same cycle cancel out
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // cpu_ready is registered from the next occupancy
    assign ready_nxt = (count_nxt != CNT_W'(DEPTH));

    // Next-state and registered-output logic
    always_comb begin
        state_nxt    = state;
        io_valid_nxt = io_valid_q;
        io_req_nxt   = io_req_q;
        rd_valid_nxt = 1'b0;
        rd_data_nxt  = rd_data_q;
        pop          = 1'b0;
`ifdef MMIO_TIMEOUT_EN
        err_nxt      = 1'b0;
        tmo_nxt      = tmo_q;
`endif
        case (state)
            IDLE: begin
                // io_ready_data is ignored here; only a queued entry matters
                if (count != '0) begin
                    io_req_nxt   = head;
                    io_valid_nxt = 1'b1;
                    pop          = 1'b1;
                    state_nxt    = ISSUE;
`ifdef MMIO_TIMEOUT_EN
                    tmo_nxt      = '0;
`endif
                end
            end
            ISSUE: begin
                if (bus.io_ready_data) begin
                    io_valid_nxt = 1'b0;
                    state_nxt    = IDLE;
                    if (!io_req_q.rw) begin
                        rd_valid_nxt = 1'b1;
                        rd_data_nxt  = bus.io_rd_data;
                    end
`ifdef MMIO_TIMEOUT_EN
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    // Completion in the expiry cycle is handled above and wins
                    io_valid_nxt = 1'b0;
                    state_nxt    = IDLE;
                    err_nxt      = 1'b1;
                    if (!io_req_q.rw) begin
                        rd_valid_nxt = 1'b1;
                        rd_data_nxt  = DATA_W'(32'hDEADBEEF);
                    end
                end else begin
                    tmo_nxt = tmo_q + TMO_W'(1);
`endif
                end
            end
            default: begin
                state_nxt    = IDLE;
                io_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, pointers and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            cpu_ready_q <= 1'b0;
            io_valid_q  <= 1'b0;
            io_req_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
`ifdef MMIO_TIMEOUT_EN
            err_q       <= 1'b0;
            tmo_q       <= '0;
`endif
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            cpu_ready_q <= ready_nxt;
            io_valid_q  <= io_valid_nxt;
            io_req_q    <= io_req_nxt;
            rd_valid_q  <= rd_valid_nxt;
            rd_data_q   <= rd_data_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
`ifdef MMIO_TIMEOUT_EN
            err_q       <= err_nxt;
            tmo_q       <= tmo_nxt;
`endif
        end
    end

    // Request storage; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= req_in;
        end
    end

    assign bus.cpu_ready     = cpu_ready_q;
    assign bus.cpu_rd_valid  = rd_valid_q;
    assign bus.cpu_rd_data   = rd_data_q;
    assign bus.io_valid_data = io_valid_q;
    assign bus.io_rw_data    = io_req_q.rw;
    assign bus.mem_addr      = io_req_q.addr;
    assign bus.io_wr_data    = io_req_q.wr_data;
`ifdef MMIO_TIMEOUT_EN
    assign bus.cpu_err       = err_q;
`else
    assign bus.cpu_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_req_queue.sv
// Testbench for mmio_req_queue: directed steps plus $urandom traffic, checked
// against a request-queue/occupancy reference model and a SPART responder.
module tb_mmio_req_queue;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 28;
    localparam int unsigned DATA_W = 32;
`ifdef MMIO_TIMEOUT_EN
    localparam int unsigned TMO = 16;
`else
    localparam int unsigned TMO = 1024;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mmio_req_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mmio_req_queue #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    cmd_t exp_q[$];
    int   issue_gaps[$];
    int   total = 0, bad = 0;
    int   tick_n = 0, accepted = 0, issued = 0, age = 0;
    int   issue_tick = 0, accept_tick = 0, last_len = 0, rd_pulses = 0, was = 0;
    logic acc_last = 1'b0;
    int   rdy_mode = 0, rdy_lat = 0;
    logic use_fixed = 1'b0;
    logic [DATA_W-1:0] fixed_rd = '0;
    logic [DATA_W-1:0] exp_rd_data = '0;

    // Inputs as applied before the edge, outputs as observed after the previous edge
    logic              p_cpu_valid, p_cpu_rw, p_io_ready;
    logic [ADDR_W-1:0] p_cpu_addr, p_mem_addr;
    logic [DATA_W-1:0] p_cpu_wd, p_io_rd, p_io_wd;
    logic              p_cpu_ready, p_io_valid, p_io_rw;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic capture_outputs();
        p_cpu_ready = bus.cpu_ready;
        p_io_valid  = bus.io_valid_data;
        p_io_rw     = bus.io_rw_data;
        p_mem_addr  = bus.mem_addr;
        p_io_wd     = bus.io_wr_data;
    endtask

    // Reference model: accepted requests queue up and must leave in order,
    // one outstanding at a time, with occupancy = accepted - issued.
    task automatic monitor();
        int   pend;
        logic cmpl, tmo;
        cmd_t c;
        tick_n++;
        pend = accepted - issued;
        acc_last = p_cpu_valid && p_cpu_ready;
        if (acc_last) begin
            c.rw = p_cpu_rw; c.addr = p_cpu_addr; c.data = p_cpu_wd;
            exp_q.push_back(c);
            accepted++;
            accept_tick = tick_n;
        end
        cmpl = p_io_valid && p_io_ready;
        tmo  = 1'b0;
`ifdef MMIO_TIMEOUT_EN
        tmo  = p_io_valid && !p_io_ready && (age == TMO);
`endif
        if (cmpl || tmo) begin
            chk("gap_low", 64'(bus.io_valid_data), 64'(0));
            chk("resp_pulse", 64'({bus.cpu_rd_valid, bus.cpu_err}), 64'({!p_io_rw, tmo}));
            if (!p_io_rw) begin
                exp_rd_data = cmpl ? p_io_rd : 32'hDEADBEEF;
                rd_pulses++;
            end
            chk("rd_data", 64'(bus.cpu_rd_data), 64'(exp_rd_data));
            last_len = tick_n - issue_tick;
        end else begin
            chk("resp_idle", 64'({bus.cpu_rd_valid, bus.cpu_err}), 64'(0));
            chk("rd_hold", 64'(bus.cpu_rd_data), 64'(exp_rd_data));
            if (p_io_valid) begin
                chk("cmd_hold",
                    64'({bus.io_valid_data, bus.io_rw_data, bus.mem_addr, bus.io_wr_data}),
                    64'({1'b1, p_io_rw, p_mem_addr, p_io_wd}));
            end else begin
                chk("issue_when", 64'(bus.io_valid_data), 64'(pend > 0));
                if (bus.io_valid_data) begin
                    chk("issue_avail", 64'(exp_q.size() > 0), 64'(1));
                    if (exp_q.size() > 0) c = exp_q.pop_front();
                    else begin c.rw = 1'b0; c.addr = '0; c.data = '0; end
                    chk("issue_cmd", 64'({bus.io_rw_data, bus.mem_addr, bus.io_wr_data}),
                        64'({c.rw, c.addr, c.data}));
                    issue_gaps.push_back(tick_n - issue_tick);
                    issued++;
                    issue_tick = tick_n;
                    age = 0;
                end
            end
        end
        if (bus.io_valid_data) age++;
        chk("ready", 64'(bus.cpu_ready), 64'((accepted - issued) != DEPTH));
        capture_outputs();
    endtask

    // SPART responder: 0 never ready, 1 always, 2 random, 3 fixed latency
    task automatic respond();
        bus.io_rd_data = use_fixed ? fixed_rd : DATA_W'($urandom());
        case (rdy_mode)
            0:       bus.io_ready_data = 1'b0;
            1:       bus.io_ready_data = 1'b1;
            2:       bus.io_ready_data = 1'($urandom_range(0, 1));
            default: bus.io_ready_data = bus.io_valid_data && (age > rdy_lat);
        endcase
    endtask

    task automatic tick();
        p_cpu_valid = bus.cpu_valid;
        p_cpu_rw    = bus.cpu_rw;
        p_cpu_addr  = bus.cpu_addr;
        p_cpu_wd    = bus.cpu_wr_data;
        p_io_ready  = bus.io_ready_data;
        p_io_rd     = bus.io_rd_data;
        @(posedge clk);
        #1;
        monitor();
        respond();
    endtask

    // Present a request and hold it until accepted (valid left high)
    task automatic send(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.cpu_valid   = 1'b1;
        bus.cpu_rw      = rw;
        bus.cpu_addr    = a;
        bus.cpu_wr_data = d;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (acc_last) return;
        end
        chk("send_accept", 64'(acc_last), 64'(1));
    endtask

    task automatic drain();
        bus.cpu_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && !bus.io_valid_data) break;
            tick();
        end
        chk("drain", 64'((exp_q.size() != 0) || bus.io_valid_data), 64'(0));
    endtask

    initial begin
        rst = 1'b0;
        bus.cpu_valid = 1'b0; bus.cpu_rw = 1'b0; bus.cpu_addr = '0; bus.cpu_wr_data = '0;
        bus.io_ready_data = 1'b0; bus.io_rd_data = '0;

        // Reset: everything low
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_ctrl", 64'({bus.cpu_ready, bus.cpu_rd_valid, bus.cpu_err,
                                 bus.io_rw_data, bus.io_valid_data}), 64'(0));
            chk("rst_cmd", 64'({bus.mem_addr, bus.io_wr_data}), 64'(0));
            chk("rst_rdata", 64'(bus.cpu_rd_data), 64'(0));
        end
        rst = 1'b1;
        capture_outputs();

        // Idle after release
        repeat (10) begin
            tick();
            chk("idle_valid", 64'(bus.io_valid_data), 64'(0));
        end
        chk("idle_ready", 64'(bus.cpu_ready), 64'(1));

        // Single read, SPART ready 3 cycles after valid
        rdy_mode = 3; rdy_lat = 3; use_fixed = 1'b1; fixed_rd = 32'hA5A5_0042;
        send(1'b0, 28'h000_0004, '0);
        bus.cpu_valid = 1'b0;
        was = rd_pulses;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rd_pulses != was) break;
        end
        chk("rd_seen", 64'(rd_pulses - was), 64'(1));
        chk("issue_lat", 64'(issue_tick - accept_tick), 64'(1));
        chk("valid_len", 64'(last_len), 64'(4));
        chk("rd_value", 64'(bus.cpu_rd_data), 64'(32'hA5A5_0042));
        repeat (3) tick();
        chk("rd_keep", 64'(bus.cpu_rd_data), 64'(32'hA5A5_0042));
        use_fixed = 1'b0;

        // Fill with SPART stalled, then overflow attempt
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) send(1'b1, ADDR_W'($urandom()), $urandom());
        chk("full_ready", 64'(bus.cpu_ready), 64'(0));
        bus.cpu_rw = 1'b1; bus.cpu_addr = 28'h0ABC_DEF; bus.cpu_wr_data = 32'h1234_5678;
        repeat (4) begin
            tick();
            chk("held_off", 64'(acc_last), 64'(0));
        end
        rdy_mode = 3; rdy_lat = 2;
        send(1'b1, 28'h0ABC_DEF, 32'h1234_5678);
        drain();

        // Mixed write/read/write with SPART always ready
        rdy_mode = 1;
        issue_gaps.delete();
        was = rd_pulses;
        send(1'b1, 28'h000_0100, 32'h1111_1111);
        send(1'b0, 28'h000_0104, 32'h0);
        send(1'b1, 28'h000_0108, 32'h3333_3333);
        drain();
        chk("one_read", 64'(rd_pulses - was), 64'(1));
        chk("issue_gap2", 64'(issue_gaps.size() > 1 ? issue_gaps[1] : 0), 64'(2));
        chk("issue_gap3", 64'(issue_gaps.size() > 2 ? issue_gaps[2] : 0), 64'(2));

        // Enqueue and dequeue in the same cycle at DEPTH-1 entries
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) send(1'b1, ADDR_W'($urandom()), $urandom());
        bus.cpu_valid = 1'b0;
        tick();
        rdy_mode = 3; rdy_lat = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus.io_valid_data) break;
        end
        bus.cpu_valid = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = 28'h0000_0FC; bus.cpu_wr_data = '0;
        tick();
        chk("simul_acc", 64'(acc_last), 64'(1));
        chk("simul_issue", 64'(bus.io_valid_data), 64'(1));
        chk("simul_ready", 64'(bus.cpu_ready), 64'(1));
        drain();

        // Twelve sequential requests to wrap the pointers, random SPART timing
        rdy_mode = 2;
        for (int i = 0; i < 12; i++) send(1'($urandom()), ADDR_W'($urandom()), $urandom());
        drain();

        // Random traffic with idle gaps
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.cpu_valid = 1'b0;
                tick();
            end else begin
                send(1'($urandom()), ADDR_W'($urandom()), $urandom());
            end
        end
        drain();

`ifdef MMIO_TIMEOUT_EN
        // Read that SPART never answers, followed by a normal write
        rdy_mode = 0;
        was = rd_pulses;
        send(1'b0, 28'h000_0200, '0);
        send(1'b1, 28'h000_0204, 32'h5555_AAAA);
        bus.cpu_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rd_pulses != was) break;
        end
        chk("tmo_seen", 64'(rd_pulses - was), 64'(1));
        chk("tmo_len", 64'(last_len), 64'(TMO));
        chk("tmo_data", 64'(bus.cpu_rd_data), 64'(32'hDEADBEEF));
        rdy_mode = 1;
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
